// File: rtl/mdio_master_arb.sv
// Clause-22 MDIO station-management master with two round-robin requesters.
// A granted transaction is serialised as preamble, ST, OP, PHYAD, REGAD, TA
// and DATA fields. MDC is derived from clk and runs only while a frame is active.
module mdio_master_arb #(
   parameter int CLK_DIV      = 4,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [9:0]  req_phyad,
   input  logic [9:0]  req_regad,
   input  logic [31:0] req_wdata,
   output logic [1:0]  req_ack,
   output logic [15:0] rd_data,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_oe,
   input  logic        mdio_in
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_DONE
   } state_t;

   localparam int PW = $clog2(2 * CLK_DIV);
   localparam int CW = (PREAMBLE_LEN > 32) ? $clog2(PREAMBLE_LEN) : 5;
   localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_END  = PW'(2 * CLK_DIV - 1);

   state_t         state_r;
   logic [PW-1:0]  ph_r;
   logic [CW-1:0]  cnt_r;
   logic           prio_r;
   logic           owner_r;
   logic           wr_r;
   logic [31:0]    sh_r;
   logic [15:0]    rd_shift_r;
   logic [1:0]     ack_r;
   logic [15:0]    rd_data_r;
   logic           busy_r;
   logic           mdc_r;
   logic           out_r;
   logic           oe_r;

   logic           gnt_valid_s;
   logic           gnt_sel_s;
   logic           gnt_wr_s;
   logic [31:0]    frame_s;
   state_t         nxt_state_s;

   // Index of the last bit of each field; counters restart at every field.
   function automatic logic [CW-1:0] field_last(input state_t st);
      case (st)
         S_PRE:   field_last = CW'(PREAMBLE_LEN - 1);
         S_ST:    field_last = CW'(1);
         S_OP:    field_last = CW'(1);
         S_PHY:   field_last = CW'(4);
         S_REG:   field_last = CW'(4);
         S_TA:    field_last = CW'(1);
         S_DATA:  field_last = CW'(15);
         default: field_last = CW'(0);
      endcase
   endfunction

   // Field order within a frame.
   function automatic state_t field_next(input state_t st);
      case (st)
         S_PRE:   field_next = S_ST;
         S_ST:    field_next = S_OP;
         S_OP:    field_next = S_PHY;
         S_PHY:   field_next = S_REG;
         S_REG:   field_next = S_TA;
         S_TA:    field_next = S_DATA;
         S_DATA:  field_next = S_DONE;
         default: field_next = S_IDLE;
      endcase
   endfunction

   // Round-robin pick: on contention the requester not granted last wins.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_sel_s   = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_valid_s = 1'b1;
         gnt_sel_s   = prio_r;
      end else if (req_valid[0]) begin
         gnt_valid_s = 1'b1;
         gnt_sel_s   = 1'b0;
      end else if (req_valid[1]) begin
         gnt_valid_s = 1'b1;
         gnt_sel_s   = 1'b1;
      end else begin
         gnt_valid_s = 1'b0;
         gnt_sel_s   = 1'b0;
      end
   end

   // Post-preamble bits of the granted request, MSB sent first.
   always_comb begin
      gnt_wr_s = gnt_sel_s ? req_write[1] : req_write[0];
      frame_s  = {2'b01,
                  gnt_wr_s ? 2'b01 : 2'b10,
                  gnt_sel_s ? req_phyad[9:5] : req_phyad[4:0],
                  gnt_sel_s ? req_regad[9:5] : req_regad[4:0],
                  gnt_wr_s ? 2'b10 : 2'b11,
                  gnt_wr_s ? (gnt_sel_s ? req_wdata[31:16] : req_wdata[15:0]) : 16'hFFFF};
   end

   // Field that the next bit belongs to.
   always_comb begin
      nxt_state_s = state_r;
      if (cnt_r == field_last(state_r)) begin
         nxt_state_s = field_next(state_r);
      end else begin
         nxt_state_s = state_r;
      end
   end

   // Frame sequencer: arbitration, MDC phase, bit shifting and completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= S_IDLE;
         ph_r       <= '0;
         cnt_r      <= '0;
         prio_r     <= 1'b0;
         owner_r    <= 1'b0;
         wr_r       <= 1'b0;
         sh_r       <= 32'h0000_0000;
         rd_shift_r <= 16'h0000;
         ack_r      <= 2'b00;
         rd_data_r  <= 16'h0000;
         busy_r     <= 1'b0;
         mdc_r      <= 1'b0;
         out_r      <= 1'b1;
         oe_r       <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               ph_r  <= '0;
               mdc_r <= 1'b0;
               ack_r <= 2'b00;
               cnt_r <= '0;
               if (gnt_valid_s) begin
                  state_r <= S_PRE;
                  busy_r  <= 1'b1;
                  owner_r <= gnt_sel_s;
                  prio_r  <= ~gnt_sel_s;
                  wr_r    <= gnt_wr_s;
                  sh_r    <= frame_s;
                  out_r   <= 1'b1;
                  oe_r    <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
                  out_r  <= 1'b1;
                  oe_r   <= 1'b0;
               end
            end
            S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA: begin
               if (ph_r == PH_END) begin
                  ph_r    <= '0;
                  mdc_r   <= 1'b0;
                  state_r <= nxt_state_s;
                  if (nxt_state_s != state_r) begin
                     cnt_r <= '0;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
                  if (nxt_state_s == S_DONE) begin
                     out_r <= 1'b1;
                     oe_r  <= 1'b0;
                     ack_r <= owner_r ? 2'b10 : 2'b01;
                     if (!wr_r) begin
                        rd_data_r <= rd_shift_r;
                     end
                  end else if (nxt_state_s == S_PRE) begin
                     out_r <= 1'b1;
                     oe_r  <= 1'b1;
                  end else begin
                     out_r <= sh_r[31];
                     sh_r  <= {sh_r[30:0], 1'b0};
                     oe_r  <= wr_r | ((nxt_state_s != S_TA) && (nxt_state_s != S_DATA));
                  end
               end else begin
                  ph_r <= ph_r + PW'(1);
                  if (ph_r == PH_RISE) begin
                     mdc_r <= 1'b1;
                     if ((state_r == S_DATA) && !wr_r) begin
                        rd_shift_r <= {rd_shift_r[14:0], mdio_in};
                     end
                  end
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
               ack_r   <= 2'b00;
               busy_r  <= 1'b0;
               ph_r    <= '0;
               mdc_r   <= 1'b0;
               out_r   <= 1'b1;
               oe_r    <= 1'b0;
            end
            default: begin
               state_r <= S_IDLE;
               ack_r   <= 2'b00;
               busy_r  <= 1'b0;
               ph_r    <= '0;
               cnt_r   <= '0;
               mdc_r   <= 1'b0;
               out_r   <= 1'b1;
               oe_r    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ack  = ack_r;
   assign rd_data  = rd_data_r;
   assign busy     = busy_r;
   assign mdc      = mdc_r;
   assign mdio_out = out_r;
   assign mdio_oe  = oe_r;

endmodule
